// File: rtl/scrod_trg_endpoint_if.sv
// Trigger-handshake bundle between a SCROD lane endpoint and its surrounding logic.
// The endpoint connects through the slave modport; the driving side uses master.
interface scrod_trg_endpoint_if #(
  parameter int unsigned CNT_W = 16
);
  logic                 ENABLE;
  logic                 LOCAL_HIT;
  logic                 TRG_IN;
  logic                 READOUT_DONE;
  logic                 ACK_OUT;
  logic                 READOUT_START;
  logic                 BUSY;
  logic [2*CNT_W-1:0]   TRG_STATISTICS;

  modport master (
    output ENABLE, LOCAL_HIT, TRG_IN, READOUT_DONE,
    input  ACK_OUT, READOUT_START, BUSY, TRG_STATISTICS
  );

  modport slave (
    input  ENABLE, LOCAL_HIT, TRG_IN, READOUT_DONE,
    output ACK_OUT, READOUT_START, BUSY, TRG_STATISTICS
  );
endinterface

// File: rtl/scrod_trg_endpoint.sv
// SCROD-side ACK/TRG trigger endpoint: request, trigger accept, readout busy and deadtime.
// Optional saturating accept/miss statistics are built only when TRG_ENDPOINT_STATS_EN is defined.
module scrod_trg_endpoint #(
  parameter int unsigned REQ_TIMEOUT = 64,
  parameter int unsigned DEADTIME    = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  CLK_80MHZ,
  input  logic                  RESET_N,
  scrod_trg_endpoint_if.slave   bus
);

  localparam int unsigned TMAX = (REQ_TIMEOUT > DEADTIME) ? REQ_TIMEOUT : DEADTIME;
  localparam int unsigned TW   = $clog2(TMAX) + 1;

  typedef logic [TW-1:0] timer_t;

  localparam timer_t REQ_LAST  = timer_t'(REQ_TIMEOUT - 1);
  localparam timer_t DEAD_LAST = timer_t'(DEADTIME - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    READOUT,
    DEAD
  } state_t;

  state_t state, state_n;
  timer_t timer, timer_n;

  logic trg_sync1, trg_sync2, trg_sync3;
  logic trg_edge, trg_evt;
  logic ack, ack_n;
  logic rstart, rstart_n;
  logic busy, busy_n;

  // Two-flop synchroniser, edge register, then one pipeline stage on the
  // detected edge so READOUT_START lands on the cycle after edge k+3.
  always_ff @(posedge CLK_80MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      trg_sync1 <= 1'b0;
      trg_sync2 <= 1'b0;
      trg_sync3 <= 1'b0;
      trg_evt   <= 1'b0;
    end else begin
      trg_sync1 <= bus.TRG_IN;
      trg_sync2 <= trg_sync1;
      trg_sync3 <= trg_sync2;
      trg_evt   <= trg_edge;
    end
  end

  assign trg_edge = trg_sync2 & ~trg_sync3;

  always_comb begin
    state_n = state;
    timer_n = timer;
    case (state)
      IDLE: begin
        if (trg_evt) begin
          state_n = READOUT;
        end else if (bus.LOCAL_HIT && bus.ENABLE) begin
          state_n = REQUEST;
          timer_n = '0;
        end
      end
      REQUEST: begin
        if (trg_evt) begin
          state_n = READOUT;
        end else if (timer == REQ_LAST) begin
          state_n = DEAD;
          timer_n = '0;
        end else begin
          timer_n = timer + timer_t'(1);
        end
      end
      READOUT: begin
        if (bus.READOUT_DONE) begin
          state_n = DEAD;
          timer_n = '0;
        end
      end
      DEAD: begin
        if (timer == DEAD_LAST) begin
          state_n = IDLE;
        end else begin
          timer_n = timer + timer_t'(1);
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase

    ack_n    = (state_n == REQUEST);
    busy_n   = (state_n == READOUT) || (state_n == DEAD);
    rstart_n = (state_n == READOUT) && (state != READOUT);
  end

  always_ff @(posedge CLK_80MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      timer  <= '0;
      ack    <= 1'b0;
      rstart <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      ack    <= ack_n;
      rstart <= rstart_n;
      busy   <= busy_n;
    end
  end

  assign bus.ACK_OUT       = ack;
  assign bus.READOUT_START = rstart;
  assign bus.BUSY          = busy;

`ifdef TRG_ENDPOINT_STATS_EN
  typedef logic [CNT_W-1:0] cnt_t;

  cnt_t accept_cnt, miss_cnt;
  logic accept_inc, miss_inc;

  // A timeout miss (REQUEST) and an ignored trigger (READOUT/DEAD) can never
  // coincide, so a single-step increment per cycle is sufficient.
  assign accept_inc = rstart_n;
  assign miss_inc   = (trg_evt && ((state == READOUT) || (state == DEAD))) ||
                      ((state == REQUEST) && !trg_evt && (timer == REQ_LAST));

  always_ff @(posedge CLK_80MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      accept_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      if (accept_inc && (accept_cnt != '1)) begin
        accept_cnt <= accept_cnt + cnt_t'(1);
      end
      if (miss_inc && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + cnt_t'(1);
      end
    end
  end

  assign bus.TRG_STATISTICS = {miss_cnt, accept_cnt};
`else
  assign bus.TRG_STATISTICS = '0;
`endif

endmodule

// File: tb/tb_scrod_trg_endpoint.sv
// Bench for scrod_trg_endpoint: scenario table, reset/saturation sequences, random traffic
// against a transaction-level reference model using absolute deadlines.
module tb_scrod_trg_endpoint;

  localparam int unsigned RT = 64;
  localparam int unsigned DT = 16;
  localparam int unsigned CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_RO   = 2;
  localparam int M_DEAD = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scrod_trg_endpoint_if #(.CNT_W(CW)) bus ();

  scrod_trg_endpoint #(
    .REQ_TIMEOUT (RT),
    .DEADTIME    (DT),
    .CNT_W       (CW)
  ) dut (
    .CLK_80MHZ (clk),
    .RESET_N   (rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int failures = 0;

  // reference model
  int       m_mode;
  longint   m_deadline;
  int       m_acc, m_miss;
  logic [7:0] m_hist;
  logic     m_rs;
  longint   cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_deadline = 0;
    m_acc = 0;
    m_miss = 0;
    m_hist = '0;
    m_rs = 1'b0;
  endtask

  // History bit [2] is TRG_IN three edges ago, [3] four edges ago: the FSM
  // sees the rising edge three edges after TRG_IN was first sampled high.
  task automatic model_edge(input logic en, input logic hit, input logic tin, input logic done);
    logic evt;
    evt = m_hist[2] & ~m_hist[3];
    m_hist = {m_hist[6:0], tin};
    m_rs = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (evt) begin
          m_mode = M_RO; m_rs = 1'b1; m_acc = sat_inc(m_acc);
        end else if (hit && en) begin
          m_mode = M_REQ; m_deadline = cyc + RT;
        end
      end
      M_REQ: begin
        if (evt) begin
          m_mode = M_RO; m_rs = 1'b1; m_acc = sat_inc(m_acc);
        end else if (cyc == m_deadline) begin
          m_mode = M_DEAD; m_deadline = cyc + DT; m_miss = sat_inc(m_miss);
        end
      end
      M_RO: begin
        if (evt) m_miss = sat_inc(m_miss);
        if (done) begin
          m_mode = M_DEAD; m_deadline = cyc + DT;
        end
      end
      default: begin
        if (evt) m_miss = sat_inc(m_miss);
        if (cyc == m_deadline) m_mode = M_IDLE;
      end
    endcase
  endtask

  function automatic logic [2*CW-1:0] exp_stats();
    logic [2*CW-1:0] e;
    e = '0;
`ifdef TRG_ENDPOINT_STATS_EN
    e = {m_miss[CW-1:0], m_acc[CW-1:0]};
`endif
    return e;
  endfunction

  task automatic tick();
    logic en, hit, tin, done;
    @(posedge clk);
    en = bus.ENABLE; hit = bus.LOCAL_HIT; tin = bus.TRG_IN; done = bus.READOUT_DONE;
    model_edge(en, hit, tin, done);
    cyc++;
    #1;
    check("ack_out", 64'(bus.ACK_OUT), 64'(m_mode == M_REQ));
    check("readout_start", 64'(bus.READOUT_START), 64'(m_rs));
    check("busy", 64'(bus.BUSY), 64'((m_mode == M_RO) || (m_mode == M_DEAD)));
    check("trg_statistics", 64'(bus.TRG_STATISTICS), 64'(exp_stats()));
  endtask

  task automatic idle_inputs();
    bus.ENABLE = 1'b1;
    bus.LOCAL_HIT = 1'b0;
    bus.TRG_IN = 1'b0;
    bus.READOUT_DONE = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", 64'(bus.ACK_OUT), 64'd0);
    check("reset_start", 64'(bus.READOUT_START), 64'd0);
    check("reset_busy", 64'(bus.BUSY), 64'd0);
    check("reset_stats", 64'(bus.TRG_STATISTICS), 64'd0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int hit_at, hit_len, trg_at, trg_len, trg2_at, done_at, en_off_at, len;
    int e_rs, e_ack, e_busy, e_acc, e_miss;
  } scen_t;

  scen_t scen [9];

  task automatic run_scen(input int idx, input scen_t s);
    int n_rs, n_ack, n_busy;
    logic [2*CW-1:0] st0, st1;
    n_rs = 0; n_ack = 0; n_busy = 0;
    st0 = bus.TRG_STATISTICS;
    for (int i = 0; i < s.len; i++) begin
      bus.ENABLE = !((s.en_off_at >= 0) && (i >= s.en_off_at));
      bus.LOCAL_HIT = (s.hit_at >= 0) && (i >= s.hit_at) && (i < s.hit_at + s.hit_len);
      bus.TRG_IN = ((s.trg_at >= 0) && (i >= s.trg_at) && (i < s.trg_at + s.trg_len)) ||
                   ((s.trg2_at >= 0) && (i >= s.trg2_at) && (i < s.trg2_at + 2));
      bus.READOUT_DONE = (i == s.done_at);
      tick();
      n_rs += int'(bus.READOUT_START);
      n_ack += int'(bus.ACK_OUT);
      n_busy += int'(bus.BUSY);
    end
    idle_inputs();
    st1 = bus.TRG_STATISTICS;
    check($sformatf("scen%0d_start_pulses", idx), 64'(n_rs), 64'(s.e_rs));
    check($sformatf("scen%0d_ack_cycles", idx), 64'(n_ack), 64'(s.e_ack));
    check($sformatf("scen%0d_busy_cycles", idx), 64'(n_busy), 64'(s.e_busy));
`ifdef TRG_ENDPOINT_STATS_EN
    check($sformatf("scen%0d_accept_delta", idx), 64'(st1[CW-1:0] - st0[CW-1:0]), 64'(s.e_acc));
    check($sformatf("scen%0d_miss_delta", idx), 64'(st1[2*CW-1:CW] - st0[2*CW-1:CW]), 64'(s.e_miss));
`else
    check($sformatf("scen%0d_stats_zero", idx), 64'(st1 | st0), 64'd0);
`endif
  endtask

  initial begin
    //              hit  hl  trg tl  trg2 done enoff len  rs ack busy acc miss
    scen[0] = '{    0,   1,  20,  5,  -1,  40,  -1,  80,  1, 23,  33,  1,  0};
    scen[1] = '{    0,   1,  -1,  0,  -1,  -1,  -1, 100,  0, 64,  16,  0,  1};
    scen[2] = '{   -1,   0,   0,  3,  -1,  10,  -1,  40,  1,  0,  23,  1,  0};
    scen[3] = '{   -1,   0,   0,  2,  10,  30,  -1,  70,  1,  0,  43,  1,  1};
    scen[4] = '{    3,   1,   0,  3,  -1,  10,  -1,  40,  1,  0,  23,  1,  0};
    scen[5] = '{    0,   1,  61,  3,  -1,  70,  -1, 100,  1, 64,  22,  1,  0};
    scen[6] = '{    0,   1,  -1,  0,  -1,  -1,   5, 100,  0, 64,  16,  0,  1};
    scen[7] = '{    0,   3,  -1,  0,  -1,  -1,   0,  20,  0,  0,   0,  0,  0};
    scen[8] = '{   -1,   0,   0, 60,  -1,  10,  -1,  60,  1,  0,  23,  1,  0};

    cyc = 0;
    do_reset();

    for (int i = 0; i < 9; i++) run_scen(i, scen[i]);
    repeat (5) tick();

    // asynchronous reset while in READOUT, then a fresh request
    bus.TRG_IN = 1'b1;
    repeat (3) tick();
    bus.TRG_IN = 1'b0;
    repeat (3) tick();
    check("pre_reset_busy", 64'(bus.BUSY), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_ack", 64'(bus.ACK_OUT), 64'd0);
    check("async_reset_start", 64'(bus.READOUT_START), 64'd0);
    check("async_reset_busy", 64'(bus.BUSY), 64'd0);
    check("async_reset_stats", 64'(bus.TRG_STATISTICS), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.LOCAL_HIT = 1'b1;
    tick();
    bus.LOCAL_HIT = 1'b0;
    check("post_reset_ack_rises", 64'(bus.ACK_OUT), 64'd1);
    repeat (90) tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.ENABLE = ($urandom_range(0, 9) != 0);
      bus.LOCAL_HIT = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) bus.TRG_IN = ~bus.TRG_IN;
      bus.READOUT_DONE = ($urandom_range(0, 11) == 0);
      tick();
    end
    idle_inputs();
    repeat (100) tick();

    // counter saturation: more accepted triggers than the counter can hold
    do_reset();
    for (int t = 0; t < CMAX + 3; t++) begin
      for (int i = 0; i < 30; i++) begin
        bus.TRG_IN = (i < 3);
        bus.READOUT_DONE = (i == 6);
        tick();
      end
    end
    idle_inputs();
`ifdef TRG_ENDPOINT_STATS_EN
    check("accept_saturated", 64'(bus.TRG_STATISTICS[CW-1:0]), 64'(CMAX));
    check("miss_after_saturation", 64'(bus.TRG_STATISTICS[2*CW-1:CW]), 64'd0);
`else
    check("stats_tied_zero", 64'(bus.TRG_STATISTICS), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
